// File: rtl/counter_down_parameter_pkg.sv
// Shared types and helpers for the loadable down-counter timer.
package counter_down_parameter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Clamp a requested start value to the largest supported count.
  function automatic logic [31:0] sat_load(input logic [31:0] value,
                                           input logic [31:0] max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/counter_down_parameter_if.sv
// Load handshake, run controls and status outputs of the down-counter timer.
interface counter_down_parameter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             periodic;
  logic             enable;
  logic             abort;
  logic [WIDTH-1:0] counter;
  logic             tc;
  logic             busy;

  modport master (
    output load_valid, load_value, periodic, enable, abort,
    input  load_ready, counter, tc, busy
  );

  modport slave (
    input  load_valid, load_value, periodic, enable, abort,
    output load_ready, counter, tc, busy
  );
endinterface

// File: rtl/counter_down_parameter.sv
// Loadable down-counter: counts a saturated start value to 0, pulses tc, then
// reloads (periodic) or stops (one-shot).
module counter_down_parameter
  import counter_down_parameter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VALUE = 200
) (
  input logic                      clk,
  input logic                      RST,
  counter_down_parameter_if.slave  bus
);

  localparam logic [31:0] MaxValue = 32'(MAX_VALUE);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic             tc_q, tc_d;

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    tc_d       = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        // A load beats a same-cycle abort.
        if (bus.load_valid) begin
          reload_d   = WIDTH'(sat_load(32'(bus.load_value), MaxValue));
          counter_d  = WIDTH'(sat_load(32'(bus.load_value), MaxValue));
          periodic_d = bus.periodic;
          state_d    = StRun;
        end else if (bus.abort) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (bus.abort) begin
          counter_d = '0;
          state_d   = StIdle;
        end else if (bus.enable) begin
          if (counter_q != '0) begin
            counter_d = counter_q - WIDTH'(1);
          end else begin
            tc_d = 1'b1;
            if (periodic_q) begin
              counter_d = reload_q;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      default: begin
        counter_d = '0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= StIdle;
      counter_q  <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      tc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      tc_q       <= tc_d;
    end
  end

  assign bus.counter    = counter_q;
  assign bus.tc         = tc_q;
  assign bus.busy       = (state_q == StRun);
  assign bus.load_ready = (state_q != StRun);

endmodule

// File: tb/tb_counter_down_parameter.sv
// Directed and random stimulus against a tick-count reference model of the timer.
module tb_counter_down_parameter;

  localparam int unsigned W    = 8;
  localparam int unsigned MAXV = 200;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  counter_down_parameter_if #(.WIDTH(W)) bus ();

  counter_down_parameter #(
    .WIDTH     (W),
    .MAX_VALUE (MAXV)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a running load is described by its reload R, mode and the number of
  // enabled edges seen since the load; the count follows from those directly.
  bit m_run   = 1'b0;
  bit m_per   = 1'b0;
  bit m_tc    = 1'b0;
  int m_r     = 0;
  int m_ticks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model();
    int v;
    m_tc = 1'b0;
    if (RST) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (bus.load_valid) begin
        v       = int'(bus.load_value);
        m_r     = (v > int'(MAXV)) ? int'(MAXV) : v;
        m_per   = bus.periodic;
        m_ticks = 0;
        m_run   = 1'b1;
      end
    end else if (bus.abort) begin
      m_run = 1'b0;
    end else if (bus.enable) begin
      m_ticks++;
      if (m_per) begin
        m_tc = (m_ticks % (m_r + 1)) == 0;
      end else if (m_ticks == m_r + 1) begin
        m_tc  = 1'b1;
        m_run = 1'b0;
      end
    end
  endtask

  function automatic int exp_counter();
    if (!m_run) return 0;
    return m_per ? m_r - (m_ticks % (m_r + 1)) : m_r - m_ticks;
  endfunction

  task automatic step(input string tag);
    @(posedge clk);
    model();
    #1;
    check({tag, ".counter"},    32'(bus.counter),    32'(exp_counter()));
    check({tag, ".tc"},         32'(bus.tc),         32'(m_tc));
    check({tag, ".busy"},       32'(bus.busy),       32'(m_run));
    check({tag, ".load_ready"}, 32'(bus.load_ready), 32'(!m_run));
  endtask

  task automatic drive(input bit lv, input int val, input bit per, input bit en, input bit ab);
    bus.load_valid = lv;
    bus.load_value = W'(val);
    bus.periodic   = per;
    bus.enable     = en;
    bus.abort      = ab;
  endtask

  initial begin
    RST = 1'b1;
    drive(0, 0, 0, 0, 0);
    step("reset_init");
    RST = 1'b0;
    step("idle");

    // Reset mid-count.
    drive(1, 9, 0, 1, 0);
    step("rst_load");
    drive(0, 0, 0, 1, 0);
    repeat (4) step("rst_run");
    check("rst_pre_counter", 32'(bus.counter), 32'd5);
    RST = 1'b1;
    repeat (2) step("rst_hold");
    RST = 1'b0;

    // One-shot load 3: 3,2,1,0 then tc, then quiet.
    drive(1, 3, 0, 1, 0);
    step("os_load");
    drive(0, 0, 0, 1, 0);
    repeat (6) step("os_run");

    // Periodic with enable gaps.
    drive(1, 2, 1, 1, 0);
    step("per_load");
    drive(0, 0, 0, 1, 0); step("per_e1");
    drive(0, 0, 0, 0, 0); step("per_e0");
    drive(0, 0, 0, 1, 0); step("per_e1b");
    step("per_e1c");
    check("per_reload_tc", 32'(bus.tc), 32'd1);
    repeat (4) step("per_more");
    drive(0, 0, 0, 0, 1);
    step("per_abort");

    // Saturation, then load 0.
    drive(1, 255, 0, 0, 0);
    step("sat_load");
    check("sat_value", 32'(bus.counter), 32'(MAXV));
    drive(0, 0, 0, 0, 1);
    step("sat_abort");
    drive(1, 0, 0, 1, 0);
    step("zero_load");
    drive(0, 0, 0, 1, 0);
    step("zero_tc");
    step("zero_done");

    // Periodic load 0: tc every enabled cycle.
    drive(1, 0, 1, 1, 0);
    step("zp_load");
    drive(0, 0, 0, 1, 0);
    repeat (3) step("zp_run");
    drive(0, 0, 0, 0, 1);
    step("zp_abort");

    // Abort on the terminal-count edge, then load+abort together in DONE.
    drive(1, 1, 0, 1, 0);
    step("race_load");
    drive(0, 0, 0, 1, 0);
    step("race_dec");
    drive(0, 0, 0, 1, 1);
    step("race_abort_tc");
    drive(1, 0, 0, 1, 0);
    step("done_load");
    drive(0, 0, 0, 1, 0);
    step("done_tc");
    drive(1, 7, 1, 1, 1);
    step("done_load_abort");
    drive(0, 0, 0, 0, 1);
    step("done_abort2");

    // load_valid held through RUN: accepted only once ready.
    drive(1, 2, 0, 1, 0);
    repeat (8) step("hs_hold");
    drive(0, 0, 0, 0, 1);
    step("hs_abort");

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      RST = ($urandom_range(0, 79) == 0);
      drive(($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 6)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 31) == 0));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
